// File: rtl/acum_frame_ctrl.sv
// Frame-bounded accumulator controller: start/length command, sample handshake, result handshake.
// Optional build macro ACUM_SATURATE_EN clamps the sum at 2^ACC_W-1 instead of wrapping.
module acum_frame_ctrl #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 6,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_len,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [ACC_W-1:0]  o_result,
  output logic              o_overflow,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  state_t             state_r, state_s;
  logic [ACC_W-1:0]   acc_r, acc_s;
  logic               ovf_r, ovf_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [ACC_W:0]     sum_s;

  // One extra bit catches the carry out of the accumulator.
  function automatic logic [ACC_W:0] add_sample(input logic [ACC_W-1:0] acc,
                                                input logic [DATA_W-1:0] data);
    add_sample = {1'b0, acc} + (ACC_W+1)'(data);
  endfunction

  assign sum_s = add_sample(acc_r, i_data);

  // State register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    ovf_s   = ovf_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (i_start) begin
          acc_s   = ACC_ZERO;
          ovf_s   = 1'b0;
          cnt_s   = i_len;
          state_s = (i_len == CNT_ZERO) ? DONE : ACCUM;
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (i_valid) begin
          cnt_s = cnt_r - CNT_ONE;
`ifdef ACUM_SATURATE_EN
          if (sum_s[ACC_W] || ovf_r) begin
            acc_s = {ACC_W{1'b1}};
          end else begin
            acc_s = sum_s[ACC_W-1:0];
          end
`else
          acc_s = sum_s[ACC_W-1:0];
`endif
          ovf_s = ovf_r | sum_s[ACC_W];
          if (cnt_r == CNT_ONE) begin
            state_s = DONE;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = ACCUM;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Datapath registers; the result holds after DONE until the next start
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_r <= ACC_ZERO;
      ovf_r <= 1'b0;
      cnt_r <= CNT_ZERO;
    end else begin
      acc_r <= acc_s;
      ovf_r <= ovf_s;
      cnt_r <= cnt_s;
    end
  end

  assign o_ready    = (state_r == ACCUM);
  assign o_valid    = (state_r == DONE);
  assign o_busy     = (state_r != IDLE);
  assign o_result   = acc_r;
  assign o_overflow = ovf_r;

endmodule

// File: tb/tb_acum_frame_ctrl.sv
// Self-checking bench for acum_frame_ctrl: directed frames plus randomized frames vs. a sum model.
module tb_acum_frame_ctrl;

  localparam int DATA_W = 4;
  localparam int ACC_W  = 6;
  localparam int CNT_W  = 4;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [CNT_W-1:0]  i_len = '0;
  logic [DATA_W-1:0] i_data = '0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [ACC_W-1:0]  o_result;
  logic              o_overflow;
  logic              o_valid;
  logic              i_ready = 1'b0;
  logic              o_busy;

  int errors = 0;
  int checks = 0;
  int samp_q[$];

  acum_frame_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_len(i_len),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_result(o_result), .o_overflow(o_overflow), .o_valid(o_valid),
    .i_ready(i_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: frame result from the plain arithmetic total of the samples.
  function automatic int model_result(input int total);
`ifdef ACUM_SATURATE_EN
    return (total > ACC_MAX) ? ACC_MAX : total;
`else
    return total % (ACC_MAX + 1);
`endif
  endfunction

  function automatic int model_ovf(input int total);
    return (total > ACC_MAX) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one frame from samp_q; gap<0 selects random gaps; bp = cycles of i_ready low.
  task automatic run_frame(input string tag, input int len, input int gap, input int bp);
    int total;
    int g;
    int res;
    total = 0;
    i_start = 1'b1;
    i_len   = CNT_W'(len);
    tick();
    i_start = 1'b0;
    i_len   = CNT_W'($urandom);
    for (int i = 0; i < len; i++) begin
      g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
      for (int k = 0; k < g; k++) begin
        i_valid = 1'b0;
        i_data  = DATA_W'($urandom);
        tick();
        check({tag, "_gap_busy"}, int'(o_busy), 1);
      end
      check({tag, "_ready"}, int'(o_ready), 1);
      i_valid = 1'b1;
      i_data  = DATA_W'(samp_q[i]);
      total  += samp_q[i];
      tick();
      i_valid = 1'b0;
    end
    res = model_result(total);
    check({tag, "_valid"}, int'(o_valid), 1);
    check({tag, "_result"}, int'(o_result), res);
    check({tag, "_ovf"}, int'(o_overflow), model_ovf(total));
    check({tag, "_done_ready"}, int'(o_ready), 0);
    for (int k = 0; k < bp; k++) begin
      i_start = 1'b1;
      i_valid = 1'b1;
      i_data  = DATA_W'($urandom);
      tick();
      check({tag, "_bp_valid"}, int'(o_valid), 1);
      check({tag, "_bp_result"}, int'(o_result), res);
      check({tag, "_bp_ovf"}, int'(o_overflow), model_ovf(total));
    end
    i_start = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check({tag, "_idle_valid"}, int'(o_valid), 0);
    check({tag, "_idle_busy"}, int'(o_busy), 0);
    check({tag, "_hold_result"}, int'(o_result), res);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_result", int'(o_result), 0);
    check("rst_ovf", int'(o_overflow), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_ready", int'(o_ready), 0);
    check("rst_busy", int'(o_busy), 0);
    i_rst_n = 1'b1;
    tick();

    // Basic frame
    samp_q = '{3, 5, 7, 9};
    run_frame("basic", 4, 0, 0);

    // Overflow
    samp_q = '{15, 15, 15, 15, 15};
    run_frame("ovf", 5, 0, 0);

    // Zero length directly after an overflowing frame, with i_valid held high
    i_valid = 1'b1;
    i_data  = 4'd9;
    i_start = 1'b1;
    i_len   = 4'd0;
    tick();
    i_start = 1'b0;
    check("zero_valid", int'(o_valid), 1);
    check("zero_result", int'(o_result), 0);
    check("zero_ovf", int'(o_overflow), 0);
    check("zero_ready", int'(o_ready), 0);
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check("zero_idle", int'(o_busy), 0);

    // Gaps and back-pressure with ignored start/valid in DONE
    samp_q = '{1, 2, 4};
    run_frame("gaps", 3, 2, 3);

    // Reset mid-frame
    i_start = 1'b1;
    i_len   = 4'd6;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1;
      i_data  = 4'd10;
      tick();
    end
    i_valid = 1'b0;
    check("mid_busy_pre", int'(o_busy), 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("mid_rst_result", int'(o_result), 0);
    check("mid_rst_busy", int'(o_busy), 0);
    check("mid_rst_ready", int'(o_ready), 0);
    check("mid_rst_valid", int'(o_valid), 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    tick();
    samp_q = '{1, 1};
    run_frame("post_rst", 2, 0, 0);

    // Back-to-back frames after an overflowing one
    samp_q = '{15, 15, 15, 15, 15};
    run_frame("b2b_ovf", 5, 0, 0);
    samp_q = '{8, 8};
    run_frame("b2b_a", 2, 0, 0);
    samp_q = '{5};
    run_frame("b2b_b", 1, 0, 0);

    // Randomized frames, including max length
    for (int f = 0; f < 24; f++) begin
      int len;
      len = (f == 0) ? ((1 << CNT_W) - 1) : int'($urandom_range((1 << CNT_W) - 1, 0));
      samp_q = {};
      for (int i = 0; i < len; i++) samp_q.push_back(int'($urandom_range((1 << DATA_W) - 1, 0)));
      run_frame("rand", len, -1, int'($urandom_range(2, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acum_frame_ctrl.md
Name: acum_frame_ctrl

Overview:
Frame controller that sequences a sync accumulator over a programmed number of input samples. It accepts a start command with a frame length and clears the accumulator. It then accepts exactly that many samples over a valid/ready handshake and presents the frame sum plus a sticky overflow flag over a second valid/ready handshake. It sits between a sample source and a result consumer, replacing free-running accumulation with frame-bounded accumulation.

Parameters:
DATA_W, 4, input sample width (unsigned)
ACC_W, 6, result width; internal sum is ACC_W+1 bits
CNT_W, 4, frame-length width; max frame = 2^CNT_W-1 samples

Ports:
clk  input  1  clock, rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_start  input  1  start-frame strobe, sampled only in IDLE
i_len  input  CNT_W  frame length, sampled with i_start
i_data  input  DATA_W  sample, unsigned
i_valid  input  1  sample valid
o_ready  output  1  controller accepts sample
o_result  output  ACC_W  accumulated frame sum
o_overflow  output  1  sticky: frame sum exceeded 2^ACC_W-1
o_valid  output  1  result valid
i_ready  input  1  consumer accepts result
o_busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset is asynchronous and active-low, with one clock. While i_rst_n=0: state=IDLE, accumulator=0, counter=0, o_result=0, o_overflow=0, o_valid=0, o_ready=0, o_busy=0.
- Reset asserted mid-frame aborts the frame immediately. No partial result is ever presented.
- States: IDLE, ACCUM, DONE (2-bit encoded).
- IDLE:
  - o_ready=0, o_valid=0.
  - i_start=1 with i_len=L>0: clear accumulator and overflow, load counter=L, go to ACCUM.
  - i_start=1 with i_len=0: clear accumulator and overflow, go directly to DONE. Result is 0.
- ACCUM:
  - o_ready=1 combinationally.
  - A sample is accepted on a cycle with i_valid&o_ready.
  - On accept: sum = {1'b0,acc} + zero-extended i_data, computed ACC_W+1 wide. acc <= sum[ACC_W-1:0] (wrap). If sum[ACC_W]=1, set o_overflow; it stays set until the next start.
  - Counter decrements per accept.
  - Cycles with i_valid=0 leave all state unchanged; gaps are allowed indefinitely.
  - When the accepted sample has counter==1, go to DONE on the next edge.
- DONE:
  - o_valid=1. o_result and o_overflow are held stable while o_valid=1.
  - o_valid&i_ready: go to IDLE on the next edge. o_result and o_overflow keep their value until the next start.
- Latency:
  - o_valid rises on the cycle after the last sample accept.
  - For L=0, o_valid rises on the cycle after i_start.
  - Minimum frame period is L+2 cycles (start, L accepts, one DONE cycle with i_ready=1).
- i_start is ignored in ACCUM and DONE; no queuing.
- i_len is sampled only on the start cycle. Later changes have no effect on the running frame.
- o_ready=0 in IDLE and DONE. i_valid asserted there is ignored and no data is consumed.
- Overflow is flagged on the accept that crosses 2^ACC_W. Repeated crossings in a frame keep the flag at 1.
- o_busy=1 in ACCUM and DONE.

Optional Feature:
- Macro: ACUM_SATURATE_EN.
- Defined: on overflow, acc <= 2^ACC_W-1 and stays saturated for the rest of the frame. o_overflow is set as above.
- Not defined: acc wraps modulo 2^ACC_W (default). o_overflow is identical in both builds.

Test Plan:
- Basic frame: start L=4, samples 3,5,7,9, i_ready=1 → o_valid for 1 cycle one cycle after the 4th accept; o_result=24, o_overflow=0; back in IDLE the following cycle.
- Overflow: start L=5, five samples of 15 (sum 75) → wrap build o_result=11, o_overflow=1; ACUM_SATURATE_EN build o_result=63, o_overflow=1.
- Handshake gaps and back-pressure: L=3, samples 1,2,4 with i_valid low for 2 cycles between each → o_result=7. Hold i_ready=0 for 3 cycles → o_valid stays 1 and the result is stable. Pulse i_start and i_valid during DONE → ignored. Release i_ready → IDLE.
- Zero length: start L=0 → o_valid=1 next cycle, o_result=0, o_overflow=0, no sample consumed (o_ready stays 0).
- Reset mid-frame: L=6, accept 2 samples of 10, assert i_rst_n=0 asynchronously between edges → all outputs 0 immediately, state IDLE. Release, start L=2 with samples 1,1 → o_result=2 (no residue from the aborted frame).
- Back-to-back frames: frame of L=2 (8,8) then restart on the first IDLE cycle with L=1 (5) → results 16 then 5; overflow cleared between frames after a prior overflowing frame.
